// File: rtl/frame_pcie_buf_pkg.sv
// Shared types and sizing helpers for the frame-to-PCIe bank buffer.
// Optional output register is selected with FRAME_PCIE_BUF_OUT_REG_EN.
package frame_pcie_buf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        FULL_WAIT = 2'd2
    } wr_state_t;

    function automatic int ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Length field holds 1..bank_words, so it needs one bit beyond the address.
    function automatic int len_width(input int bank_words);
        return $clog2(bank_words) + 1;
    endfunction

endpackage

// File: rtl/frame_pcie_buf_ram.sv
// Single-clock simple dual-port RAM, registered read, optional extra output stage.
// FRAME_PCIE_BUF_OUT_REG_EN adds the second stage (read latency 2 instead of 1).
module frame_pcie_buf_ram
    import frame_pcie_buf_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q_reg;
    logic             ram_v_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q_reg <= '0;
            ram_v_reg <= 1'b0;
        end else begin
            ram_v_reg <= rd_en;
            if (rd_en) begin
                ram_q_reg <= mem[rd_addr];
            end
        end
    end

`ifdef FRAME_PCIE_BUF_OUT_REG_EN
    logic [WIDTH-1:0] out_q_reg;
    logic             out_v_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_reg <= '0;
            out_v_reg <= 1'b0;
        end else begin
            out_q_reg <= ram_q_reg;
            out_v_reg <= ram_v_reg;
        end
    end

    assign rd_data  = out_q_reg;
    assign rd_valid = out_v_reg;
`else
    assign rd_data  = ram_q_reg;
    assign rd_valid = ram_v_reg;
`endif

endmodule

// File: rtl/frame_pcie_bank_buf.sv
// Packs a narrow pixel stream into wide words and hands whole banks to a DMA reader.
// FRAME_PCIE_BUF_OUT_REG_EN (in the RAM) selects read latency 2 instead of 1.
module frame_pcie_bank_buf
    import frame_pcie_buf_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 128,
    parameter int BANK_WORDS = 256,
    parameter int NUM_BANKS  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        bank_avail,
    output logic [$clog2(BANK_WORDS):0] bank_len,
    input  logic                        rd_en,
    input  logic [$clog2(BANK_WORDS)-1:0] rd_addr,
    output logic [OUT_WIDTH-1:0]        rd_data,
    output logic                        rd_valid,
    input  logic                        bank_release,
    output logic                        rel_err
);

    localparam int R      = ratio(OUT_WIDTH, IN_WIDTH);
    localparam int LANE_W = idx_width(R);
    localparam int A_W    = idx_width(BANK_WORDS);
    localparam int BANK_W = idx_width(NUM_BANKS);
    localparam int LEN_W  = len_width(BANK_WORDS);
    localparam int CNT_W  = BANK_W + 1;

    wr_state_t          state_reg;
    logic [OUT_WIDTH-1:0] pack_reg;
    logic [OUT_WIDTH-1:0] wr_word;
    logic [LANE_W-1:0]  lane_reg;
    logic [A_W-1:0]     wr_ptr_reg;
    logic [BANK_W-1:0]  wr_bank_reg;
    logic [BANK_W-1:0]  rd_bank_reg;
    logic [CNT_W-1:0]   full_cnt_reg;
    logic [CNT_W-1:0]   full_cnt_next;
    logic [LEN_W-1:0]   len_reg [NUM_BANKS];
    logic               in_ready_reg;
    logic               bank_avail_reg;
    logic               rel_err_reg;

    logic accept, wr_en, close, rel_ok;

    assign accept = in_valid & in_ready_reg;
    assign wr_en  = accept & ((lane_reg == LANE_W'(R - 1)) | in_last);
    assign close  = wr_en & (in_last | (wr_ptr_reg == A_W'(BANK_WORDS - 1)));
    assign rel_ok = bank_release & (full_cnt_reg != '0);

    // Lanes above the current one are still zero in pack_reg, which gives the
    // zero padding for a short last word for free.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_lane
            assign wr_word[gi*IN_WIDTH +: IN_WIDTH] =
                (lane_reg == LANE_W'(gi)) ? in_data : pack_reg[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    always_comb begin
        full_cnt_next = full_cnt_reg;
        if (close && !rel_ok) begin
            full_cnt_next = full_cnt_reg + CNT_W'(1);
        end else if (!close && rel_ok) begin
            full_cnt_next = full_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_reg    <= '0;
            lane_reg    <= '0;
            wr_ptr_reg  <= '0;
            wr_bank_reg <= '0;
        end else if (accept) begin
            if (wr_en) begin
                pack_reg <= '0;
                lane_reg <= '0;
            end else begin
                pack_reg <= wr_word;
                lane_reg <= lane_reg + LANE_W'(1);
            end
            if (close) begin
                wr_ptr_reg  <= '0;
                wr_bank_reg <= wr_bank_reg + BANK_W'(1);
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + A_W'(1);
            end
        end
    end

    // Write-side FSM; flow-control outputs are registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            full_cnt_reg   <= '0;
            rd_bank_reg    <= '0;
            in_ready_reg   <= 1'b1;
            bank_avail_reg <= 1'b0;
            rel_err_reg    <= 1'b0;
        end else begin
            full_cnt_reg   <= full_cnt_next;
            in_ready_reg   <= (full_cnt_next < CNT_W'(NUM_BANKS));
            bank_avail_reg <= (full_cnt_next != '0);
            if (rel_ok) begin
                rd_bank_reg <= rd_bank_reg + BANK_W'(1);
            end
            if (bank_release && full_cnt_reg == '0) begin
                rel_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!close) begin
                            state_reg <= FILL;
                        end else if (full_cnt_next == CNT_W'(NUM_BANKS)) begin
                            state_reg <= FULL_WAIT;
                        end
                    end
                end
                FILL: begin
                    if (close) begin
                        state_reg <= (full_cnt_next == CNT_W'(NUM_BANKS)) ? FULL_WAIT : IDLE;
                    end
                end
                FULL_WAIT: begin
                    if (rel_ok) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_len
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    len_reg[gi] <= '0;
                end else if (close && wr_bank_reg == BANK_W'(gi)) begin
                    len_reg[gi] <= {1'b0, wr_ptr_reg} + LEN_W'(1);
                end
            end
        end
    endgenerate

    assign in_ready   = in_ready_reg;
    assign bank_avail = bank_avail_reg;
    assign bank_len   = bank_avail_reg ? len_reg[rd_bank_reg] : '0;
    assign rel_err    = rel_err_reg;

    frame_pcie_buf_ram #(
        .WIDTH  (OUT_WIDTH),
        .DEPTH  (NUM_BANKS * BANK_WORDS),
        .ADDR_W (BANK_W + A_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  ({wr_bank_reg, wr_ptr_reg}),
        .wr_data  (wr_word),
        .rd_en    (rd_en),
        .rd_addr  ({rd_bank_reg, rd_addr}),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_frame_pcie_bank_buf.sv
// Directed bench for frame_pcie_bank_buf with a read-data scoreboard queue.
module tb_frame_pcie_bank_buf;

`ifdef FRAME_PCIE_BUF_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         bank_avail;
    logic [8:0]   bank_len;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = '0;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         bank_release = 1'b0;
    logic         rel_err;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];

    frame_pcie_bank_buf dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .bank_avail   (bank_avail),
        .bank_len     (bank_len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .bank_release (bank_release),
        .rel_err      (rel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and retire read data.
    task automatic step();
        logic [127:0] exp;
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_valid_unexpected", 128'(rd_valid), 128'd0);
            end else begin
                exp = sb_q.pop_front();
                chk("rd_data", rd_data, exp);
                $display("read  data=%h expected=%h", rd_data, exp);
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [127:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        sb_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 1) step();
        chk("sb_empty", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic release_bank();
        bank_release = 1'b1;
        step();
        bank_release = 1'b0;
    endtask

    function automatic logic [127:0] pack8(input int base);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(base + k);
        return r;
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_bank_avail", 128'(bank_avail), 128'd0);
        chk("rst_bank_len", 128'(bank_len), 128'd0);
        chk("rst_rd_valid", 128'(rd_valid), 128'd0);
        chk("rst_rd_data", rd_data, 128'd0);
        chk("rst_rel_err", 128'(rel_err), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // One full bank from 2048 increasing words
        for (int i = 0; i < 2048; i++) send(16'(i), 1'b0);
        chk("full_bank_avail", 128'(bank_avail), 128'd1);
        chk("full_bank_len", 128'(bank_len), 128'd256);
        chk("full_in_ready", 128'(in_ready), 128'd1);
        rd(8'd0, pack8(0));
        rd(8'd255, pack8(2040));
        rd(8'd100, pack8(800));
        rd(8'd37, pack8(296));
        drain();

        // Second bank fills the buffer; an offered word must be held off
        for (int i = 2048; i < 4096; i++) send(16'(i), 1'b0);
        chk("both_full_in_ready", 128'(in_ready), 128'd0);
        in_data  = 16'hBEEF;
        in_valid = 1'b1;
        in_last  = 1'b1;
        repeat (3) step();
        chk("held_in_ready", 128'(in_ready), 128'd0);
        chk("held_bank_len", 128'(bank_len), 128'd256);
        release_bank();
        in_valid = 1'b1;
        chk("post_release_in_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("refull_in_ready", 128'(in_ready), 128'd0);
        chk("refull_bank_avail", 128'(bank_avail), 128'd1);
        chk("head_bank1_len", 128'(bank_len), 128'd256);
        rd(8'd0, pack8(2048));
        rd(8'd255, pack8(4088));
        drain();

        // Held word became a one-word bank with zero padding
        release_bank();
        chk("held_word_len", 128'(bank_len), 128'd1);
        rd(8'd0, 128'h0000_0000_0000_0000_0000_0000_0000_BEEF);
        drain();
        release_bank();
        chk("empty_bank_avail", 128'(bank_avail), 128'd0);
        chk("empty_bank_len", 128'(bank_len), 128'd0);

        // Short line: 11 words, last on word 10
        for (int i = 0; i < 10; i++) send(16'(i), 1'b0);
        send(16'd10, 1'b1);
        chk("short_bank_len", 128'(bank_len), 128'd2);
        rd(8'd0, pack8(0));
        rd(8'd1, 128'h0000_0000_0000_0000_0000_000A_0009_0008);
        drain();

        // Close and release in the same cycle with one bank pending
        send(16'h0100, 1'b0);
        send(16'h0101, 1'b0);
        in_data      = 16'h0102;
        in_valid     = 1'b1;
        in_last      = 1'b1;
        bank_release = 1'b1;
        step();
        in_valid     = 1'b0;
        in_last      = 1'b0;
        bank_release = 1'b0;
        chk("cr_bank_avail", 128'(bank_avail), 128'd1);
        chk("cr_bank_len", 128'(bank_len), 128'd1);
        chk("cr_in_ready", 128'(in_ready), 128'd1);
        rd(8'd0, 128'h0000_0000_0000_0000_0000_0102_0101_0100);
        drain();
        release_bank();
        chk("cr_count_one", 128'(bank_avail), 128'd0);

        // Release with nothing pending
        chk("rel_err_clear", 128'(rel_err), 128'd0);
        release_bank();
        chk("rel_err_set", 128'(rel_err), 128'd1);
        chk("rel_err_avail", 128'(bank_avail), 128'd0);
        chk("rel_err_len", 128'(bank_len), 128'd0);
        step();
        send(16'h0055, 1'b1);
        chk("rel_err_sticky", 128'(rel_err), 128'd1);
        chk("rel_err_close_avail", 128'(bank_avail), 128'd1);
        release_bank();

        // Reset mid-line with a closed bank pending and a partial pack
        send(16'h0077, 1'b1);
        for (int i = 0; i < 5; i++) send(16'(16'h0011 + i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_bank_avail", 128'(bank_avail), 128'd0);
        chk("mid_rst_bank_len", 128'(bank_len), 128'd0);
        chk("mid_rst_rd_valid", 128'(rd_valid), 128'd0);
        chk("mid_rst_rd_data", rd_data, 128'd0);
        chk("mid_rst_rel_err", 128'(rel_err), 128'd0);
        step();
        #2;
        rst = 1'b0;
        step();
        send(16'h0021, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0023, 1'b1);
        chk("post_rst_avail", 128'(bank_avail), 128'd1);
        chk("post_rst_len", 128'(bank_len), 128'd1);
        rd(8'd0, 128'h0000_0000_0000_0000_0000_0023_0022_0021);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
